// File: rtl/pla_pkg.sv
// Shared definitions for the programmable PLA AND-plane:
// literal codes, load FSM states and the literal match function.
package pla_pkg;

  localparam logic [1:0] LIT_ONE  = 2'b10;
  localparam logic [1:0] LIT_ZERO = 2'b01;
  localparam logic [1:0] LIT_DC   = 2'b11;
  localparam logic [1:0] LIT_NULL = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAR,
    COMMIT
  } state_t;

  function automatic logic lit_match(
    input logic [1:0] lit,
    input logic       x
  );
    logic m;
    case (lit)
      LIT_ONE:  m = x;
      LIT_ZERO: m = ~x;
      LIT_DC:   m = 1'b1;
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pla_row_eval.sv
// One product term: AND of N_IN literal matches.
// Ports: lits (row literal codes, col 0 in [1:0]), in (plane inputs), hit.
module pla_row_eval
  import pla_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0][1:0] lits,
  input  logic [N_IN-1:0]      in,
  output logic                 hit
);

  always_comb begin
    hit = 1'b1;
    for (int c = 0; c < N_IN; c++) begin
      hit = hit & lit_match(lits[c], in[c]);
    end
  end

endmodule

// File: rtl/pla_prog_plane.sv
// Programmable AND-plane: serial personality load into a shadow matrix,
// atomic commit to the active matrix, registered product-term evaluation.
// Ports: clk, rst_b (async low), prog_start/valid/data/ready load port,
// load_done pulse, load_err (sticky parity error), in, term.
// Define PLA_PARITY_EN to add a per-row parity beat and a live load_err.
module pla_prog_plane
  import pla_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_ROWS = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [1:0]        prog_data,
  output logic              prog_ready,
  output logic              load_done,
  output logic              load_err,
  input  logic [N_IN-1:0]   in,
  output logic [N_ROWS-1:0] term
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);

  state_t state, state_nxt;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [N_ROWS-1:0][N_IN-1:0][1:0] shadow;
  logic [N_ROWS-1:0][N_IN-1:0][1:0] active;
  logic [N_ROWS-1:0] hit;

  logic take;
  logic row_end;
  logic last_row;
  logic par_ok;

  // A beat coinciding with prog_start is dropped.
  assign take     = prog_valid && prog_ready && !prog_start;
  assign row_end  = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign par_ok   = (prog_data[0] == ^shadow[row]);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    prog_ready = 1'b0;
    load_done  = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid && row_end) begin
`ifdef PLA_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = last_row ? COMMIT : LOAD;
`endif
        end
      end
      PAR: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          if (!par_ok)       state_nxt = IDLE;
          else if (last_row) state_nxt = COMMIT;
          else               state_nxt = LOAD;
        end
      end
      COMMIT: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (prog_start) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      row    <= '0;
      col    <= '0;
      shadow <= '0;
      active <= '0;
      term   <= '0;
    end else begin
      term <= hit;
      if (state == COMMIT) active <= shadow;
      if (prog_start) begin
        row <= '0;
        col <= '0;
      end else if (take && state == LOAD) begin
        shadow[row][col] <= prog_data;
        if (row_end) begin
          col <= '0;
`ifndef PLA_PARITY_EN
          row <= last_row ? '0 : row + 1'b1;
`endif
        end else begin
          col <= col + 1'b1;
        end
      end else if (take && state == PAR) begin
        if (par_ok) row <= last_row ? '0 : row + 1'b1;
      end
    end
  end

`ifdef PLA_PARITY_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      load_err <= 1'b0;
    end else if (prog_start) begin
      load_err <= 1'b0;
    end else if (take && state == PAR && !par_ok) begin
      load_err <= 1'b1;
    end
  end
`else
  assign load_err = 1'b0;
`endif

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    pla_row_eval #(
      .N_IN(N_IN)
    ) u_row (
      .lits(active[r]),
      .in  (in),
      .hit (hit[r])
    );
  end

endmodule

// File: tb/tb_pla_prog_plane.sv
// Self-checking bench for pla_prog_plane: directed vector table
// plus hand-written load, abort, gapped-valid and parity sequences.
module tb_pla_prog_plane;

  typedef logic [2:0][3:0][1:0] mat_t;
  typedef struct {
    logic [3:0] in;
    logic [2:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       prog_start = 1'b0;
  logic       prog_valid = 1'b0;
  logic [1:0] prog_data = 2'b00;
  logic [3:0] in = 4'h0;
  logic       prog_ready;
  logic       load_done;
  logic       load_err;
  logic [2:0] term;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  mat_t ma, mb;
  vec_t vecs[8];

  always #5 clk = ~clk;

  pla_prog_plane #(
    .N_IN  (4),
    .N_ROWS(3)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .prog_start(prog_start),
    .prog_valid(prog_valid),
    .prog_data (prog_data),
    .prog_ready(prog_ready),
    .load_done (load_done),
    .load_err  (load_err),
    .in        (in),
    .term      (term)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (load_done === 1'b1) pulses++;
  endtask

  function automatic logic [2:0] model(input mat_t m, input logic [3:0] x);
    logic [2:0] t;
    for (int r = 0; r < 3; r++) begin
      t[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        case (m[r][c])
          2'b10:   t[r] = t[r] & x[c];
          2'b01:   t[r] = t[r] & ~x[c];
          2'b11:   t[r] = t[r];
          default: t[r] = 1'b0;
        endcase
      end
    end
    return t;
  endfunction

  task automatic beat(input logic [1:0] d, input bit gap);
    if (gap) begin
      prog_valid = 1'b0;
      prog_data  = ~d;
      tick;
    end
    prog_valid = 1'b1;
    prog_data  = d;
    tick;
    prog_valid = 1'b0;
  endtask

  // Pulse prog_start with a bogus beat alongside; it must be dropped.
  task automatic start;
    prog_start = 1'b1;
    prog_valid = 1'b1;
    prog_data  = 2'b00;
    tick;
    prog_start = 1'b0;
  endtask

  task automatic send(input mat_t m, input int nbeats, input bit gap);
    int n;
    n = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (n < nbeats) begin
          beat(m[r][c], gap);
          n++;
        end
      end
`ifdef PLA_PARITY_EN
      if (n < nbeats) begin
        beat({1'b0, ^m[r]}, gap);
        n++;
      end
`endif
    end
  endtask

  task automatic load(input mat_t m, input bit gap, input string tag);
    pulses = 0;
    start;
    send(m, 1000, gap);
    chk({tag, "_done_pulse"}, load_done, 1);
    chk({tag, "_done_once"}, pulses, 1);
    tick;
    chk({tag, "_done_low"}, load_done, 0);
    chk({tag, "_ready_idle"}, prog_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ma[0] = 8'b11_01_11_10;
    ma[1] = 8'b01_11_10_10;
    ma[2] = 8'b01_11_11_01;
    mb[0] = 8'b11_11_00_11;
    mb[1] = 8'b11_11_11_11;
    mb[2] = 8'b11_11_01_10;
    vecs = '{
      '{4'b0001, 3'b001},
      '{4'b0011, 3'b011},
      '{4'b0000, 3'b100},
      '{4'b1000, 3'b000},
      '{4'b0101, 3'b000},
      '{4'b0111, 3'b010},
      '{4'b1011, 3'b001},
      '{4'b0100, 3'b100}
    };

    in = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_term", term, 0);
    chk("rst_ready", prog_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    rst_b = 1'b1;
    in = 4'hF;
    tick;
    chk("post_rst_term_f", term, 0);
    in = 4'h0;
    tick;
    chk("post_rst_term_0", term, 0);
    chk("post_rst_ready", prog_ready, 0);

    load(ma, 1'b0, "loadA");
    for (int i = 0; i < 8; i++) begin
      in = vecs[i].in;
      tick;
      chk($sformatf("vecA_%0d", i), term, vecs[i].exp);
    end

    pulses = 0;
    start;
    chk("load_ready", prog_ready, 1);
    send(mb, 5, 1'b0);
    in = 4'b0011;
    tick;
    chk("abort_term_011", term, 3'b011);
    in = 4'b0000;
    tick;
    chk("abort_term_100", term, 3'b100);
    chk("abort_no_done", pulses, 0);

    load(mb, 1'b1, "loadB");
    for (int x = 0; x < 16; x++) begin
      in = 4'(x);
      tick;
      chk($sformatf("vecB_%0d", x), term, model(mb, 4'(x)));
      chk($sformatf("null_row_%0d", x), term[0], 0);
    end

`ifdef PLA_PARITY_EN
    pulses = 0;
    start;
    for (int c = 0; c < 4; c++) beat(ma[0][c], 1'b0);
    beat({1'b0, ^ma[0]}, 1'b0);
    for (int c = 0; c < 4; c++) beat(ma[1][c], 1'b0);
    beat({1'b1, ~^ma[1]}, 1'b0);
    chk("par_err_set", load_err, 1);
    chk("par_ready_idle", prog_ready, 0);
    in = 4'b0011;
    tick;
    tick;
    chk("par_no_done", pulses, 0);
    chk("par_err_sticky", load_err, 1);
    chk("par_term_old", term, model(mb, 4'b0011));
    start;
    prog_valid = 1'b0;
    chk("par_err_clear", load_err, 0);
    load(ma, 1'b0, "loadA2");
    in = 4'b0011;
    tick;
    chk("reloadA_term", term, 3'b011);
`else
    chk("err_tied_low", load_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pla_prog_plane.md
# pla_prog_plane

Programmable AND-plane with a serial personality-loading port: the writer side for the PLA personality matrix and the sequential evaluator that reads it. A host streams 2-bit literal codes through a valid/ready port. The block assembles them into a shadow matrix and commits it atomically once a load is complete. Registered product-term outputs are then evaluated every cycle against the committed matrix. It sits between the configuration controller and the OR-plane / output logic of the PLA datapath.

## Interface
- N_IN, 4, number of plane inputs (literal columns per row)
- N_ROWS, 3, number of product terms (rows)
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- prog_start  input  1  one-cycle pulse; begins a new load, or aborts and restarts one in progress
- prog_valid  input  1  prog_data is valid this cycle
- prog_data  input  2  literal code: 10 = input must be 1, 01 = input must be 0, 11 = don't care, 00 = null (row never matches)
- prog_ready  output  1  block accepts a beat this cycle
- load_done  output  1  one-cycle pulse; new matrix committed
- load_err  output  1  sticky parity error flag (PLA_PARITY_EN only; otherwise tied 0); cleared by prog_start
- in  input  N_IN  plane inputs, in[0] = column 0
- term  output  N_ROWS  registered product-term outputs, term[r] = row r

## Operation
- Load FSM states:
  - IDLE: prog_ready = 0; prog_start -> LOAD.
  - LOAD: prog_ready = 1; each accepted beat (prog_valid && prog_ready) writes shadow[row][col], then col++. When col = N_IN-1: col <- 0, row++ (-> PAR if PLA_PARITY_EN). The last beat of row N_ROWS-1 (or its parity beat) -> COMMIT.
  - PAR: prog_ready = 1; one beat checks parity. prog_data[0] must equal the XOR of the row's 2*N_IN code bits, and prog_data[1] is ignored. On match, return to LOAD or go to COMMIT. On mismatch, set load_err and go to IDLE with no commit.
  - COMMIT: active <- shadow; load_done = 1 for one cycle; -> IDLE.
- Beat order: row-major, row 0 column 0 first. Total beats = N_ROWS*N_IN, or N_ROWS*(N_IN+1) with parity.
- prog_start in any state resets row/col to 0, clears load_err, and enters LOAD next cycle. A beat presented in the same cycle as prog_start is not accepted.
- prog_valid in IDLE or COMMIT is ignored.
- The active matrix changes only in COMMIT. An aborted or failed load leaves the active matrix untouched.
- Evaluation: term[r] <= AND over c of match(active[r][c], in[c]).
  - match(10, x) = x
  - match(01, x) = !x
  - match(11, x) = 1
  - match(00, x) = 0

## Timing
- Reset values: FSM = IDLE, row = col = 0, shadow and active all 00, prog_ready = 0, load_done = 0, load_err = 0, term = 0.
- Reset asserted mid-load discards the load completely.
- Evaluation latency is 1 cycle: term at edge k+1 reflects in and active as sampled at edge k.
- Commit boundary: the edge that writes active still evaluates against the old matrix. The new matrix is first visible in term one cycle after the load_done pulse.
- prog_ready is a function of state only, never of prog_valid. The host may hold prog_valid high continuously, and one beat transfers per cycle.
- load_done goes high in the cycle after the final beat is accepted.

## Configuration
- PLA_PARITY_EN defined: a parity beat follows each row, the PAR state exists, and load_err is live.
- PLA_PARITY_EN undefined: no parity beat, the PAR state is absent, and load_err is constant 0.

## Structure
- Shared package pla_pkg holds:
  - the literal code localparams LIT_ONE, LIT_ZERO, LIT_DC, LIT_NULL;
  - the FSM state enum (IDLE, LOAD, PAR, COMMIT);
  - the match function.
- Sub-module pla_row_eval is one row's AND over N_IN literals, instantiated N_ROWS times. The FSM, counters and matrix registers live in the top module.

## Test plan
- Reset release -> term = 000, prog_ready = 0, load_done = 0 for any in.
- Load rows {10,11,01,11}, {10,10,11,01}, {01,11,11,01} (in[0] first):
  - load_done pulses once, the cycle after beat 12 (15 with parity).
  - Then in = 4'b0001 (in[0] = 1) -> term = 001 (row 0 only) next cycle.
  - in = 4'b0011 -> term = 011.
  - in = 4'b0000 -> term = 100.
- prog_start issued after beat 5 of a load -> active unchanged, and term still follows the previous matrix. A complete reload of 12 beats then commits.
- prog_valid toggled 1,0,1,0 during LOAD -> only the cycles with prog_valid high advance col. The final matrix matches the intended data.
- Any row containing 00 -> that term bit stays 0 for all 16 input values.
- PLA_PARITY_EN with a wrong parity beat on row 1 -> load_err = 1, no load_done, active unchanged. The next prog_start clears load_err.
